display_arbiter: RTL and testbench
==================================

# display_arbiter

- Shares the four-digit seven-segment display between three message sources.
- Round-robin arbitration; the granted 28-bit segment word is latched and presented for a fixed dwell time, optionally rotating one digit left per step interval.
- Then the requester gets a one-cycle acknowledge.
- Output `dispOut` drives the `in` port of `SevenSegFourDig`, in place of a direct `rotatingDigits` connection.

## Interface
- `DWELL_CYCLES`, 100_000_000: cycles a granted message stays in SHOW (≥2).
- `STEP_CYCLES`, 25_000_000: cycles between one-digit rotations when rotation is enabled (≥1).
- `BLANK`, 28'hFFFFFFF: word shown when idle (all segments off, active-low).
- `clk`  input  1  system clock. One clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  3  per-requester display request; level, held until `ack` or withdrawn.
- `msg0`, `msg1`, `msg2`  input  28 each  segment words; bits [27:21] are the leftmost digit, [6:0] the rightmost.
- `rotEn`  input  3  per-requester rotation enable; sampled with the grant.
- `grant`  output  3  one-hot current grant; all zero when idle.
- `ack`  output  1  one-cycle pulse when the dwell completes.
- `busy`  output  1  high in SHOW and DONE.
- `dispOut`  output  28  registered word to `SevenSegFourDig`.

## Operation
- States: IDLE, SHOW, DONE. All outputs registered.
- Reset values: state IDLE, `grant`=0, `ack`=0, `busy`=0, `dispOut`=BLANK, last-served pointer `last`=2, counters 0.
- IDLE, any `req` bit high:
  - Choose the winner `w` by searching indices `last`+1, `last`+2, `last` (mod 3).
  - Next edge: state SHOW, `grant`=onehot(w), `dispOut`=msg_w, `rotQ`=rotEn[w], `last`=w, `busy`=1.
  - Dwell and step counters clear.
- IDLE, no `req`: hold. `dispOut` stays BLANK.
- SHOW:
  - Dwell counter increments each cycle.
  - `msg*` and `rotEn` changes are ignored; the word is latched.
  - If `rotQ`=1, the step counter counts 0..STEP_CYCLES-1.
  - On its terminal count the next edge sets `dispOut` to {dispOut[20:0], dispOut[27:21]} and the step counter wraps to 0.
- SHOW, dwell counter = DWELL_CYCLES-1: next edge goes to DONE with `ack`=1, `dispOut`=BLANK, `grant` held.
- DONE: lasts exactly one cycle. Next edge: IDLE, `ack`=0, `grant`=0, `busy`=0.
- Abort: if `req[w]` is low in any SHOW cycle, the next edge goes directly to IDLE with `grant`=0, `dispOut`=BLANK, `busy`=0 and no `ack`. `last` keeps w.
  - Abort takes precedence over dwell completion in the same cycle.
- Other requesters' `req` changes during SHOW/DONE have no effect until IDLE.
- Reset asserted in any state returns to reset values at the next edge. A pending `ack` is discarded.
- Counter widths: $clog2(DWELL_CYCLES) and $clog2(STEP_CYCLES), minimum 1 bit. No overflow is possible.

## Timing
- Request to grant/display latency: 1 cycle from the IDLE edge where `req` is sampled.
- `grant` and message are displayed for exactly DWELL_CYCLES cycles, then 1 DONE cycle with `ack` (blank display).
- At least 1 IDLE cycle separates consecutive grants. Back-to-back service period: DWELL_CYCLES+2 cycles.
- Rotation k (k≥1) takes effect in SHOW cycle k·STEP_CYCLES (0-based), only if that cycle is less than DWELL_CYCLES.
- `ack` is never high in the same cycle as `grant`=0, and never high for more than 1 cycle.

## Test plan
All scenarios use DWELL_CYCLES=8, STEP_CYCLES=3.
- Reset: hold `rst` 2 cycles with `req`=3'b111. Outputs are `grant`=0, `ack`=0, `busy`=0, `dispOut`=28'hFFFFFFF. First grant after release is 3'b001.
- Single request: `req`=3'b010, `msg1`=28'h0123456, `rotEn`=0.
  - Next cycle `grant`=010 and `dispOut`=28'h0123456 for 8 cycles.
  - Then `ack`=1 for 1 cycle with `dispOut` BLANK, then IDLE.
- Round-robin: `req`=3'b111 held, re-raised after each `ack`. Grant order is 001, 010, 100, 001, each 10 cycles apart.
- Rotation: `rotEn[0]`=1, `msg0`={7'h01,7'h02,7'h03,7'h04}.
  - SHOW cycles 0–2 show 01,02,03,04; cycles 3–5 show 02,03,04,01; cycles 6–7 show 03,04,01,02.
  - No third rotation occurs.
- Abort: grant `req[2]`, then drop `req[2]` in SHOW cycle 4. Next edge `grant`=0, `dispOut`=BLANK, no `ack`. A pending `req[0]` is granted one IDLE cycle later.
- Mid-operation reset: assert `rst` in SHOW cycle 7 (the would-be `ack` edge). The next edge shows reset values with `ack`=0, and `last` returns to 2.

Source files
------------

// File: rtl/display_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_arbiter: round-robin sharing of a 4-digit 7-seg display among     |
// | three message sources with dwell timing and optional digit rotation.      |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module display_arbiter #(
  parameter int          DWELL_CYCLES = 100_000_000,
  parameter int          STEP_CYCLES  = 25_000_000,
  parameter logic [27:0] BLANK        = 28'hFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [27:0] msg0,
  input  logic [27:0] msg1,
  input  logic [27:0] msg2,
  input  logic [2:0]  rotEn,
  output logic [2:0]  grant,
  output logic        ack,
  output logic        busy,
  output logic [27:0] dispOut
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [27:0]   disp_q, disp_d;
  logic [1:0]    last_q, last_d;
  logic          rot_q, rot_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] step_q, step_d;

  logic [1:0]    cand1, cand2, cand3;
  logic [1:0]    win;
  logic [27:0]   win_msg;

  // Search order starts just after the last-served requester.
  always_comb begin
    cand1 = 2'd0;
    cand2 = 2'd1;
    cand3 = 2'd2;
    case (last_q)
      2'd0: begin cand1 = 2'd1; cand2 = 2'd2; cand3 = 2'd0; end
      2'd1: begin cand1 = 2'd2; cand2 = 2'd0; cand3 = 2'd1; end
      default: ;
    endcase
    if (req[cand1])      win = cand1;
    else if (req[cand2]) win = cand2;
    else                 win = cand3;
    case (win)
      2'd0:    win_msg = msg0;
      2'd1:    win_msg = msg1;
      default: win_msg = msg2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    disp_d  = disp_q;
    last_d  = last_q;
    rot_d   = rot_q;
    dwell_d = dwell_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SHOW;
          grant_d = 3'b001 << win;
          disp_d  = win_msg;
          rot_d   = rotEn[win];
          last_d  = win;
          busy_d  = 1'b1;
          dwell_d = '0;
          step_d  = '0;
        end
      end
      SHOW: begin
        // A withdrawn request beats dwell completion in the same cycle.
        if (~|(req & grant_q)) begin
          state_d = IDLE;
          grant_d = 3'b000;
          disp_d  = BLANK;
          busy_d  = 1'b0;
        end else if (dwell_q == DWELL_LAST) begin
          state_d = DONE;
          ack_d   = 1'b1;
          disp_d  = BLANK;
        end else begin
          dwell_d = dwell_q + DW'(1);
          if (rot_q) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              disp_d = {disp_q[20:0], disp_q[27:21]};
            end else begin
              step_d = step_q + SW'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        grant_d = 3'b000;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        grant_d = 3'b000;
        busy_d  = 1'b0;
        disp_d  = BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      disp_q  <= BLANK;
      last_q  <= 2'd2;
      rot_q   <= 1'b0;
      dwell_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      disp_q  <= disp_d;
      last_q  <= last_d;
      rot_q   <= rot_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
    end
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign dispOut = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_display_arbiter: randomized self-checking bench for display_arbiter.   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_display_arbiter;

  localparam int          DWELL = 8;
  localparam int          STEP  = 3;
  localparam logic [27:0] BLANK = 28'hFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [27:0] msg0, msg1, msg2;
  logic [2:0]  rotEn;
  logic [2:0]  grant;
  logic        ack;
  logic        busy;
  logic [27:0] dispOut;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_m = 2;
  int grant_cyc = 0;
  int last_win = 0;

  display_arbiter #(
    .DWELL_CYCLES(DWELL),
    .STEP_CYCLES (STEP),
    .BLANK       (BLANK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .msg0   (msg0),
    .msg1   (msg1),
    .msg2   (msg2),
    .rotEn  (rotEn),
    .grant  (grant),
    .ack    (ack),
    .busy   (busy),
    .dispOut(dispOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin winner: first requester after the last served one, mod 3.
  function automatic int pick(input int last, input logic [2:0] r);
    for (int i = 1; i <= 3; i++) begin
      int c;
      c = (last + i) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Word visible in SHOW cycle k: rotated left by one digit per completed step interval.
  function automatic logic [27:0] exp_disp(input logic [27:0] m, input bit rq, input int k);
    logic [55:0] d;
    int n;
    d = {m, m};
    n = rq ? (k / STEP) % 4 : 0;
    return d[55 - 7*n -: 28];
  endfunction

  task automatic randomize_msgs();
    msg0  = 28'($urandom);
    msg1  = 28'($urandom);
    msg2  = 28'($urandom);
    rotEn = 3'($urandom);
  endtask

  task automatic run_grant(input logic [2:0] r, input logic [2:0] rot, input int abort_at,
                           input bit keep, input bit jitter);
    int w;
    logic [27:0] lat;
    logic [2:0] oh;
    bit rq;
    req   = r;
    rotEn = rot;
    w = pick(last_m, r);
    oh = 3'b001 << w;
    lat = (w == 0) ? msg0 : (w == 1) ? msg1 : msg2;
    rq = rot[w];
    step();
    last_m = w;
    last_win = w;
    grant_cyc = cyc;
    for (int k = 0; k < DWELL; k++) begin
      checks++;
      if (grant !== oh || ack !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL show_ctrl k=%0d: grant=%b ack=%b busy=%b expected grant=%b ack=0 busy=1",
                 k, grant, ack, busy, oh);
      end
      checks++;
      if (dispOut !== exp_disp(lat, rq, k)) begin
        errors++;
        $display("FAIL show_disp k=%0d: dispOut=%h expected %h", k, dispOut, exp_disp(lat, rq, k));
      end
      randomize_msgs();
      if (jitter) req = (3'($urandom) & ~oh) | oh;
      if (k == abort_at) begin
        req = req & ~oh;
        step();
        checks++;
        if (grant !== 3'b000 || ack !== 1'b0 || busy !== 1'b0 || dispOut !== BLANK) begin
          errors++;
          $display("FAIL abort: grant=%b ack=%b busy=%b disp=%h expected 000 0 0 %h",
                   grant, ack, busy, dispOut, BLANK);
        end
        return;
      end
      step();
    end
    checks++;
    if (grant !== oh || ack !== 1'b1 || busy !== 1'b1 || dispOut !== BLANK) begin
      errors++;
      $display("FAIL done: grant=%b ack=%b busy=%b disp=%h expected %b 1 1 %h",
               grant, ack, busy, dispOut, oh, BLANK);
    end
    if (!keep) req = 3'b000;
    step();
    checks++;
    if (grant !== 3'b000 || ack !== 1'b0 || busy !== 1'b0 || dispOut !== BLANK) begin
      errors++;
      $display("FAIL idle_after_done: grant=%b ack=%b busy=%b disp=%h expected 000 0 0 %h",
               grant, ack, busy, dispOut, BLANK);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b111;
    randomize_msgs();
    step();
    step();
    checks++;
    if (grant !== 3'b000 || ack !== 1'b0 || busy !== 1'b0 || dispOut !== BLANK) begin
      errors++;
      $display("FAIL reset: grant=%b ack=%b busy=%b disp=%h expected 000 0 0 %h",
               grant, ack, busy, dispOut, BLANK);
    end
    rst = 1'b0;
    req = 3'b000;
    last_m = 2;
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    int prev;
    for (int i = 0; i < 4; i++) begin
      randomize_msgs();
      run_grant(3'b111, 3'b000, -1, (i < 3), 1'b0);
      checks++;
      if (last_win !== order[i]) begin
        errors++;
        $display("FAIL rr_order i=%0d: winner=%0d expected %0d", i, last_win, order[i]);
      end
      if (i > 0) begin
        checks++;
        if (grant_cyc - prev !== DWELL + 2) begin
          errors++;
          $display("FAIL rr_period i=%0d: period=%0d expected %0d", i, grant_cyc - prev, DWELL + 2);
        end
      end
      prev = grant_cyc;
    end
  endtask

  task automatic test_single();
    msg0 = 28'($urandom);
    msg1 = 28'h0123456;
    msg2 = 28'($urandom);
    run_grant(3'b010, 3'b000, -1, 1'b0, 1'b0);
  endtask

  task automatic test_rotation();
    msg0 = {7'h01, 7'h02, 7'h03, 7'h04};
    run_grant(3'b001, 3'b001, -1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    randomize_msgs();
    run_grant(3'b101, 3'b000, 4, 1'b0, 1'b0);
    checks++;
    if (last_win !== 2) begin
      errors++;
      $display("FAIL abort_winner: winner=%0d expected 2", last_win);
    end
    randomize_msgs();
    run_grant(3'b001, 3'b000, -1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    randomize_msgs();
    req = 3'b010;
    step();
    checks++;
    if (grant !== 3'b010) begin
      errors++;
      $display("FAIL midrst_grant: grant=%b expected 010", grant);
    end
    for (int k = 0; k < DWELL - 1; k++) step();
    rst = 1'b1;
    step();
    checks++;
    if (grant !== 3'b000 || ack !== 1'b0 || busy !== 1'b0 || dispOut !== BLANK) begin
      errors++;
      $display("FAIL midrst: grant=%b ack=%b busy=%b disp=%h expected 000 0 0 %h",
               grant, ack, busy, dispOut, BLANK);
    end
    rst = 1'b0;
    req = 3'b111;
    step();
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL midrst_last: grant=%b expected 001", grant);
    end
    rst = 1'b1;
    req = 3'b000;
    step();
    rst = 1'b0;
    last_m = 2;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] r;
      int ab;
      r = 3'($urandom_range(1, 7));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DWELL - 1)) : -1;
      randomize_msgs();
      run_grant(r, 3'($urandom), ab, 1'b0, 1'b1);
      req = 3'b000;
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 3'b000;
    msg0  = '0;
    msg1  = '0;
    msg2  = '0;
    rotEn = 3'b000;
    #1;
    test_reset();
    test_round_robin();
    test_single();
    test_rotation();
    test_abort();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
